// File: rtl/hpdcache_data_resize.sv
// Width-converting FIFO for the HPDcache refill and write-back data paths.
// The width ratio selects one of three modes at elaboration:
//   - upsize: narrow words are packed into wide entries;
//   - downsize: wide entries are read out one narrow slice at a time;
//   - pass-through: a plain FIFO.
// Every mode carries a last-beat marker and a per-entry word count.
module hpdcache_data_resize #(
  parameter  int unsigned WR_WIDTH = 64,
  parameter  int unsigned RD_WIDTH = 64,
  parameter  int unsigned DEPTH    = 2,
  localparam int unsigned MAX_W    = (WR_WIDTH > RD_WIDTH) ? WR_WIDTH : RD_WIDTH,
  localparam int unsigned MIN_W    = (WR_WIDTH > RD_WIDTH) ? RD_WIDTH : WR_WIDTH,
  localparam int unsigned RATIO    = MAX_W / MIN_W,
  localparam int unsigned CNT_W    = (RATIO > 1) ? $clog2(RATIO) : 1,
  localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                w_i,
  input  logic                wlast_i,
  output logic                wok_o,
  input  logic [WR_WIDTH-1:0] wdata_i,
  input  logic                r_i,
  output logic                rok_o,
  output logic [RD_WIDTH-1:0] rdata_o,
  output logic                rlast_o,
  output logic [CNT_W:0]      rcnt_o
);

  localparam int unsigned USED_W   = $clog2(DEPTH + 1);
  localparam bit          UPSIZE   = (RD_WIDTH > WR_WIDTH);
  localparam bit          DOWNSIZE = (WR_WIDTH > RD_WIDTH);

  logic [PTR_W-1:0]  wrptr_q;
  logic [PTR_W-1:0]  rdptr_q;
  logic [USED_W-1:0] used_q;
  logic              w_acc;
  logic              r_acc;
  // close: an entry becomes readable this cycle; free: the head entry is released
  logic              close;
  logic              free;

  // Flow control depends on the occupancy register only.
  assign wok_o = (used_q != USED_W'(DEPTH));
  assign rok_o = (used_q != '0);
  assign w_acc = w_i && wok_o;
  assign r_acc = r_i && rok_o;

  // Pointer and occupancy bookkeeping shared by all modes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wrptr_q <= '0;
      rdptr_q <= '0;
      used_q  <= '0;
    end else begin
      if (close) begin
        wrptr_q <= (wrptr_q == PTR_W'(DEPTH - 1)) ? '0 : wrptr_q + PTR_W'(1);
      end
      if (free) begin
        rdptr_q <= (rdptr_q == PTR_W'(DEPTH - 1)) ? '0 : rdptr_q + PTR_W'(1);
      end
      if (close && !free) begin
        used_q <= used_q + USED_W'(1);
      end else if (!close && free) begin
        used_q <= used_q - USED_W'(1);
      end
    end
  end

  if (UPSIZE) begin : g_up
    logic [RD_WIDTH-1:0] buf_q   [DEPTH];
    logic [CNT_W-1:0]    words_q [DEPTH];
    logic                last_q  [DEPTH];
    logic [CNT_W-1:0]    slot;

    // The word count of the entry being filled doubles as the slot index.
    assign slot  = words_q[wrptr_q];
    assign close = w_acc && ((slot == CNT_W'(RATIO - 1)) || wlast_i);
    assign free  = r_acc;

    // Pack write words into the open entry; a read clears the head's metadata
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          buf_q[i]   <= '0;
          words_q[i] <= '0;
          last_q[i]  <= 1'b0;
        end
      end else begin
        // While partially full the head and the open entry are distinct.
        if (free) begin
          words_q[rdptr_q] <= '0;
          last_q[rdptr_q]  <= 1'b0;
        end
        if (w_acc) begin
          // Slot 0 starts a new entry: stale upper words from an earlier use are wiped.
          if (slot == '0) begin
            buf_q[wrptr_q] <= RD_WIDTH'(wdata_i);
          end else begin
            for (int s = 1; s < RATIO; s++) begin
              if (slot == CNT_W'(s)) begin
                buf_q[wrptr_q][s*WR_WIDTH +: WR_WIDTH] <= wdata_i;
              end
            end
          end
          if (close) begin
            last_q[wrptr_q] <= wlast_i;
          end else begin
            words_q[wrptr_q] <= slot + CNT_W'(1);
          end
        end
      end
    end

    assign rdata_o = buf_q[rdptr_q];
    // Count reads as 0 when empty so the reset value is 0.
    assign rcnt_o  = rok_o ? ({1'b0, words_q[rdptr_q]} + (CNT_W + 1)'(1)) : '0;
    assign rlast_o = last_q[rdptr_q] && rok_o;

  end else if (DOWNSIZE) begin : g_dn
    logic [WR_WIDTH-1:0] buf_q  [DEPTH];
    logic                last_q [DEPTH];
    logic [CNT_W-1:0]    slc_q;
    logic [RD_WIDTH-1:0] slice;

    assign close = w_acc;
    assign free  = r_acc && (slc_q == CNT_W'(RATIO - 1));

    // Whole-entry writes and slice stepping on reads
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          buf_q[i]  <= '0;
          last_q[i] <= 1'b0;
        end
        slc_q <= '0;
      end else begin
        if (w_acc) begin
          buf_q[wrptr_q]  <= wdata_i;
          last_q[wrptr_q] <= wlast_i;
        end
        if (r_acc) begin
          slc_q <= free ? '0 : slc_q + CNT_W'(1);
        end
      end
    end

    // Select the current slice of the head entry, slice 0 in the LSBs
    always_comb begin
      slice = '0;
      for (int s = 0; s < RATIO; s++) begin
        if (slc_q == CNT_W'(s)) begin
          slice = buf_q[rdptr_q][s*RD_WIDTH +: RD_WIDTH];
        end
      end
    end

    assign rdata_o = slice;
    assign rcnt_o  = {1'b0, slc_q};
    assign rlast_o = rok_o && last_q[rdptr_q] && (slc_q == CNT_W'(RATIO - 1));

  end else begin : g_pt
    logic [WR_WIDTH-1:0] buf_q  [DEPTH];
    logic                last_q [DEPTH];

    assign close = w_acc;
    assign free  = r_acc;

    // Plain FIFO storage
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          buf_q[i]  <= '0;
          last_q[i] <= 1'b0;
        end
      end else if (w_acc) begin
        buf_q[wrptr_q]  <= wdata_i;
        last_q[wrptr_q] <= wlast_i;
      end
    end

    assign rdata_o = buf_q[rdptr_q];
    assign rcnt_o  = (CNT_W + 1)'(1);
    assign rlast_o = rok_o && last_q[rdptr_q];
  end

endmodule

// File: tb/tb_hpdcache_data_resize.sv
// Bench for hpdcache_data_resize: three instances cover upsize (32->128),
// downsize (128->32) and pass-through (32, DEPTH=3). A queue-based model
// predicts every output each cycle; directed literals pin key results.
module tb_hpdcache_data_resize;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // upsize instance signals
  logic         up_w = 0, up_wlast = 0, up_r = 0;
  logic [31:0]  up_wdata = '0;
  logic         up_wok, up_rok, up_rlast;
  logic [127:0] up_rdata;
  logic [2:0]   up_rcnt;
  // downsize instance signals
  logic         dn_w = 0, dn_wlast = 0, dn_r = 0;
  logic [127:0] dn_wdata = '0;
  logic         dn_wok, dn_rok, dn_rlast;
  logic [31:0]  dn_rdata;
  logic [2:0]   dn_rcnt;
  // pass-through instance signals
  logic         pt_w = 0, pt_wlast = 0, pt_r = 0;
  logic [31:0]  pt_wdata = '0;
  logic         pt_wok, pt_rok, pt_rlast;
  logic [31:0]  pt_rdata;
  logic [1:0]   pt_rcnt;

  hpdcache_data_resize #(.WR_WIDTH(32), .RD_WIDTH(128), .DEPTH(2)) u_up (
    .clk_i(clk), .rst_i(rst), .w_i(up_w), .wlast_i(up_wlast), .wok_o(up_wok),
    .wdata_i(up_wdata), .r_i(up_r), .rok_o(up_rok), .rdata_o(up_rdata),
    .rlast_o(up_rlast), .rcnt_o(up_rcnt));

  hpdcache_data_resize #(.WR_WIDTH(128), .RD_WIDTH(32), .DEPTH(2)) u_dn (
    .clk_i(clk), .rst_i(rst), .w_i(dn_w), .wlast_i(dn_wlast), .wok_o(dn_wok),
    .wdata_i(dn_wdata), .r_i(dn_r), .rok_o(dn_rok), .rdata_o(dn_rdata),
    .rlast_o(dn_rlast), .rcnt_o(dn_rcnt));

  hpdcache_data_resize #(.WR_WIDTH(32), .RD_WIDTH(32), .DEPTH(3)) u_pt (
    .clk_i(clk), .rst_i(rst), .w_i(pt_w), .wlast_i(pt_wlast), .wok_o(pt_wok),
    .wdata_i(pt_wdata), .r_i(pt_r), .rok_o(pt_rok), .rdata_o(pt_rdata),
    .rlast_o(pt_rlast), .rcnt_o(pt_rcnt));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [127:0] data;
    int           cnt;
    bit           last;
  } ent_t;

  ent_t         uq[$];
  logic [127:0] up_pdata = '0;
  int           up_pcnt = 0;
  ent_t         dq[$];
  int           dslc = 0;
  ent_t         pq[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      uq.delete(); up_pdata = '0; up_pcnt = 0;
      dq.delete(); dslc = 0;
      pq.delete();
    end else begin
      bit   wa, ra;
      ent_t e;
      // upsize: words accumulate until RATIO words or a last beat
      wa = up_w && (uq.size() < 2);
      ra = up_r && (uq.size() > 0);
      if (ra) void'(uq.pop_front());
      if (wa) begin
        up_pdata[up_pcnt*32 +: 32] = up_wdata;
        up_pcnt++;
        if (up_pcnt == 4 || up_wlast) begin
          e.data = up_pdata; e.cnt = up_pcnt; e.last = up_wlast;
          uq.push_back(e);
          up_pdata = '0; up_pcnt = 0;
        end
      end
      // downsize: each entry read as four slices
      wa = dn_w && (dq.size() < 2);
      ra = dn_r && (dq.size() > 0);
      if (ra) begin
        if (dslc == 3) begin
          void'(dq.pop_front());
          dslc = 0;
        end else begin
          dslc++;
        end
      end
      if (wa) begin
        e.data = dn_wdata; e.cnt = 0; e.last = dn_wlast;
        dq.push_back(e);
      end
      // pass-through
      wa = pt_w && (pq.size() < 3);
      ra = pt_r && (pq.size() > 0);
      if (ra) void'(pq.pop_front());
      if (wa) begin
        e.data = {96'h0, pt_wdata}; e.cnt = 1; e.last = pt_wlast;
        pq.push_back(e);
      end
    end
  end

  // Per-cycle comparison of all three instances against the model
  logic [127:0] hd;
  always @(negedge clk) begin
    if (!rst) begin
      chk("up_wok", up_wok, uq.size() != 2);
      chk("up_rok", up_rok, uq.size() != 0);
      if (uq.size() > 0) begin
        chk("up_rdata", up_rdata, uq[0].data);
        chk("up_rcnt", up_rcnt, uq[0].cnt);
        chk("up_rlast", up_rlast, uq[0].last);
      end else begin
        chk("up_rlast_empty", up_rlast, 0);
      end
      chk("dn_wok", dn_wok, dq.size() != 2);
      chk("dn_rok", dn_rok, dq.size() != 0);
      if (dq.size() > 0) begin
        hd = dq[0].data;
        chk("dn_rdata", dn_rdata, hd[dslc*32 +: 32]);
        chk("dn_rcnt", dn_rcnt, dslc);
        chk("dn_rlast", dn_rlast, dq[0].last && dslc == 3);
      end else begin
        chk("dn_rlast_empty", dn_rlast, 0);
      end
      chk("pt_wok", pt_wok, pq.size() != 3);
      chk("pt_rok", pt_rok, pq.size() != 0);
      chk("pt_rcnt", pt_rcnt, 1);
      if (pq.size() > 0) begin
        chk("pt_rdata", pt_rdata, pq[0].data);
        chk("pt_rlast", pt_rlast, pq[0].last);
      end else begin
        chk("pt_rlast_empty", pt_rlast, 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic up_write(input logic [31:0] d, input logic l, input logic rd);
    up_w = 1'b1; up_wdata = d; up_wlast = l; up_r = rd;
    tick();
    up_w = 1'b0; up_wlast = 1'b0; up_r = 1'b0;
  endtask

  task automatic up_read();
    up_r = 1'b1;
    tick();
    up_r = 1'b0;
  endtask

  task automatic dn_write(input logic [127:0] d, input logic l);
    dn_w = 1'b1; dn_wdata = d; dn_wlast = l;
    tick();
    dn_w = 1'b0; dn_wlast = 1'b0;
  endtask

  task automatic pt_write(input logic [31:0] d, input logic l);
    pt_w = 1'b1; pt_wdata = d; pt_wlast = l;
    tick();
    pt_w = 1'b0; pt_wlast = 1'b0;
  endtask

  task automatic pt_read();
    pt_r = 1'b1;
    tick();
    pt_r = 1'b0;
  endtask

  logic [31:0] dexp [4];

  initial begin
    rst = 1'b1;
    tick(); tick();
    // reset state
    chk("rst_up_wok", up_wok, 1);
    chk("rst_up_rok", up_rok, 0);
    chk("rst_up_rdata", up_rdata, 0);
    chk("rst_up_rcnt", up_rcnt, 0);
    chk("rst_up_rlast", up_rlast, 0);
    chk("rst_dn_rcnt", dn_rcnt, 0);
    chk("rst_dn_rdata", dn_rdata, 0);
    chk("rst_pt_rcnt", pt_rcnt, 1);
    chk("rst_pt_rok", pt_rok, 0);
    rst = 1'b0;
    tick();

    // upsize full burst
    up_write(32'h11, 0, 0);
    up_write(32'h22, 0, 0);
    up_write(32'h33, 0, 0);
    chk("up_partial_not_readable", up_rok, 0);
    up_write(32'h44, 1, 0);
    chk("up_full_rok", up_rok, 1);
    chk("up_full_rdata", up_rdata, 128'h00000044_00000033_00000022_00000011);
    chk("up_full_rcnt", up_rcnt, 4);
    chk("up_full_rlast", up_rlast, 1);
    up_read();
    chk("up_after_read_rok", up_rok, 0);

    // fill entry 1 and drain it so the next partial burst reuses entry 0
    up_write(32'h55, 0, 0);
    up_write(32'h66, 0, 0);
    up_write(32'h77, 0, 0);
    up_write(32'h88, 0, 0);
    chk("up_nolast_rlast", up_rlast, 0);
    up_read();
    up_write(32'hAA, 0, 0);
    up_write(32'hBB, 1, 0);
    chk("up_partial_rdata", up_rdata, 128'h00000000_00000000_000000BB_000000AA);
    chk("up_partial_rcnt", up_rcnt, 2);
    chk("up_partial_rlast", up_rlast, 1);
    up_read();

    // simultaneous close and free
    up_write(32'hA1, 0, 0);
    up_write(32'hA2, 0, 0);
    up_write(32'hA3, 0, 0);
    up_write(32'hA4, 0, 0);
    up_write(32'h01, 0, 0);
    up_write(32'h02, 0, 0);
    up_write(32'h03, 0, 0);
    up_write(32'h04, 1, 1);
    chk("up_simul_rok", up_rok, 1);
    chk("up_simul_wok", up_wok, 1);
    chk("up_simul_rdata", up_rdata, 128'h00000004_00000003_00000002_00000001);
    up_read();
    chk("up_simul_drained", up_rok, 0);

    // downsize single entry
    dexp[0] = 32'h11; dexp[1] = 32'h22; dexp[2] = 32'h33; dexp[3] = 32'h44;
    dn_write(128'h00000044_00000033_00000022_00000011, 1);
    for (int i = 0; i < 4; i++) begin
      chk("dn_rok", dn_rok, 1);
      chk("dn_slice", dn_rdata, dexp[i]);
      chk("dn_rcnt_lit", dn_rcnt, i);
      chk("dn_rlast_lit", dn_rlast, i == 3);
      dn_r = 1'b1;
      tick();
      dn_r = 1'b0;
    end
    chk("dn_empty", dn_rok, 0);

    // downsize full, then streaming read of both entries
    dn_write(128'h0000000d_0000000c_0000000b_0000000a, 0);
    dn_write(128'h000000f4_000000f3_000000f2_000000f1, 1);
    chk("dn_full_wok", dn_wok, 0);
    dn_r = 1'b1;
    repeat (4) tick();
    chk("dn_second_head", dn_rdata, 32'hf1);
    chk("dn_wok_after_free", dn_wok, 1);
    repeat (4) tick();
    dn_r = 1'b0;
    chk("dn_drained", dn_rok, 0);

    // pass-through full and wrap, DEPTH=3
    pt_write(32'h100, 0);
    pt_write(32'h200, 0);
    pt_write(32'h300, 1);
    chk("pt_full_wok", pt_wok, 0);
    chk("pt_head", pt_rdata, 32'h100);
    pt_w = 1'b1; pt_wdata = 32'hDEAD;
    tick(); tick();
    pt_w = 1'b0;
    chk("pt_full_hold_wok", pt_wok, 0);
    pt_read();
    chk("pt_wok_after_read", pt_wok, 1);
    chk("pt_rdata_2", pt_rdata, 32'h200);
    chk("pt_rlast_2", pt_rlast, 0);
    pt_write(32'h400, 1);
    chk("pt_full_again", pt_wok, 0);
    pt_read();
    chk("pt_rdata_3", pt_rdata, 32'h300);
    chk("pt_rlast_3", pt_rlast, 1);
    pt_read();
    chk("pt_rdata_4", pt_rdata, 32'h400);
    chk("pt_rlast_4", pt_rlast, 1);
    pt_read();
    chk("pt_empty", pt_rok, 0);

    // reset mid-burst with one full entry queued
    up_write(32'hC1, 0, 0);
    up_write(32'hC2, 0, 0);
    up_write(32'hC3, 0, 0);
    up_write(32'hC4, 0, 0);
    up_write(32'hD1, 0, 0);
    up_write(32'hD2, 0, 0);
    chk("up_queued_rok", up_rok, 1);
    rst = 1'b1;
    #1;
    chk("rst_async_wok", up_wok, 1);
    chk("rst_async_rok", up_rok, 0);
    chk("rst_async_rdata", up_rdata, 0);
    chk("rst_async_rcnt", up_rcnt, 0);
    tick();
    rst = 1'b0;
    tick();
    up_write(32'hE1, 0, 0);
    up_write(32'hE2, 0, 0);
    up_write(32'hE3, 0, 0);
    up_write(32'hE4, 1, 0);
    chk("post_rst_rdata", up_rdata, 128'h000000E4_000000E3_000000E2_000000E1);
    chk("post_rst_rcnt", up_rcnt, 4);
    chk("post_rst_rlast", up_rlast, 1);
    up_read();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hpdcache_data_resize.md
# hpdcache_data_resize

Parametrised width-converting FIFO for the HPDcache refill/write-back data paths. It generalises the upsize-only buffer to three modes, chosen at elaboration from the width ratio: upsize, downsize, and pass-through (equal widths). In every mode it propagates a last-beat marker and reports the valid word count of each entry, so one block serves both memory-to-cache refill (narrow to wide) and cache-to-memory write-back (wide to narrow).

## Interface
Parameters:
- WR_WIDTH, 64: write-side data width in bits.
- RD_WIDTH, 64: read-side data width in bits. The larger of WR_WIDTH and RD_WIDTH must be an integer multiple of the smaller.
- DEPTH, 2: number of entries, ≥1. Each entry is max(WR_WIDTH,RD_WIDTH) wide.
- Derived: RATIO = max/min width. CNT_W = max(1,$clog2(RATIO)). PTR_W = max(1,$clog2(DEPTH)).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- w_i  in  1  write request.
- wlast_i  in  1  last write beat of a burst; sampled with w_i.
- wok_o  out  1  write accepted when w_i&&wok_o.
- wdata_i  in  WR_WIDTH  write data.
- r_i  in  1  read request.
- rok_o  out  1  read accepted when r_i&&rok_o.
- rdata_o  out  RD_WIDTH  read data.
- rlast_o  out  1  head beat is the last beat of a burst.
- rcnt_o  out  CNT_W+1  upsize: number of valid WR words in the head entry (1..RATIO). Downsize: index of the current slice. Pass-through: 1.

## Operation
- State: entry buffer, wrptr, rdptr, used (0..DEPTH), a per-entry word count, a per-entry last flag, and a read slice index (downsize only).
- Reset: all of this state is cleared to 0, and the buffer is cleared to 0. Resulting outputs: wok_o=1, rok_o=0, rlast_o=0, rcnt_o=0 (1 in pass-through), rdata_o=0.
- wok_o = (used != DEPTH). rok_o = (used != 0). Both depend only on registers.

Upsize mode (RD_WIDTH>WR_WIDTH):
- An accepted write stores wdata_i into slot words[wrptr] of entry wrptr.
- A write into slot 0 also zeroes the entry's other slots.
- The entry closes when the slot index equals RATIO-1 or wlast_i=1. On close: last[wrptr] = wlast_i, used+1, and wrptr wraps from DEPTH-1 to 0. Otherwise the word count increments.
- Read outputs:
  - rdata_o = entry rdptr.
  - rcnt_o = words[rdptr]+1.
  - rlast_o = last[rdptr] && rok_o.
- An accepted read clears words[rdptr] and last[rdptr], does used-1, and wraps rdptr.

Downsize mode (WR_WIDTH>RD_WIDTH):
- Each accepted write fills one whole entry. last[wrptr] = wlast_i, used+1, and wrptr wraps.
- Read outputs:
  - rdata_o = slice slc_q of entry rdptr (slice 0 = LSBs).
  - rcnt_o = slc_q.
  - rlast_o = rok_o && last[rdptr] && slc_q==RATIO-1.
- An accepted read increments slc_q. At RATIO-1, slc_q returns to 0, the entry is freed (used-1) and rdptr wraps.

Pass-through (equal widths):
- A plain DEPTH-entry FIFO.
- Every write closes an entry. rlast_o carries wlast_i.

Common rules:
- Simultaneous close and free in the same cycle: used is unchanged and both pointers advance.
- A write to an entry that is partially filled but not closed never makes it readable.
- Arithmetic on counters is modulo the register width. Pointers wrap explicitly at DEPTH-1, so non-power-of-2 DEPTH is supported.
- Writes while full and reads while empty are ignored; state is unchanged.
- rst_i asserted mid-burst discards all entries, including a partially filled one. The first write after reset goes to entry 0, slot 0.

## Timing
- Write-to-read latency is 1 cycle. An entry closed at edge N gives rok_o=1 and valid rdata_o from edge N, i.e. in cycle N+1.
- Free-to-write latency is 1 cycle. When full, a read accepted at edge N gives wok_o=1 in cycle N+1.
- There is no combinational path from w_i, r_i or wdata_i to any output.
- rdata_o, rlast_o and rcnt_o are stable while rok_o=1 and no read is accepted.
- Throughput:
  - Upsize: one WR beat per cycle in, one entry per cycle out.
  - Downsize: one RD slice per cycle out.
  - In all modes the block sustains full rate with DEPTH≥2.
- Reset takes effect asynchronously. Release is synchronous to clk_i.

## Test plan
- Upsize, WR=32, RD=128, DEPTH=2: write 4 beats 0x11,0x22,0x33,0x44 with wlast on beat 4. Expect rok_o=1 the cycle after beat 4, rdata_o=0x00000044_00000033_00000022_00000011, rcnt_o=4, rlast_o=1.
- Upsize partial burst: write 0xAA then 0xBB with wlast. Expect rdata_o=0x0…00BB_000000AA, rcnt_o=2, rlast_o=1, and zero in the upper slots even after a prior full entry was read from the same entry.
- Downsize, WR=128, RD=32: write 0x44..._33..._22..._11 with wlast. Read 4 beats. Expect 0x11,0x22,0x33,0x44; rcnt_o 0..3; rlast_o only on the 4th; rok_o=0 after.
- Full and wrap, DEPTH=3 pass-through: 3 writes give wok_o=0. Hold w_i=1 with 0xDEAD; it is not stored. Read 1 gives wok_o=1 next cycle. Next write lands in entry 0. Reads return the data in order.
- Simultaneous close and free, upsize, DEPTH=2, one entry stored: close the second entry while reading the first in the same cycle. used stays 1, both pointers advance, and data order is preserved.
- Reset mid-operation: assert rst_i after 2 of 4 upsize beats, with one full entry queued. Outputs go immediately to wok_o=1, rok_o=0, rdata_o=0. After release, a 4-beat burst reads back correctly from entry 0.
